// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the controller state encodings, default parameter values and a
// small helper used to size the stall/flush down-counter.
package pipeline_hazard_ctrl_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 4;
  localparam int DEF_LOAD_STALL     = 1;
  localparam int DEF_FLUSH_CYCLES   = 1;
  localparam int DEF_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2,
    HZ_HALT  = 2'd3
  } hz_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports:
//   clk   - clock, rising edge
//   RST   - asynchronous active-high reset, clears the count
//   inc   - count enable for this cycle
//   count - current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / taken-branch hazard controller with
// debugger halt and saturating performance counters.
// Ports:
//   clk, RST                    - clock and asynchronous active-high reset
//   A_addr, B_addr, a_used, b_used - decode-stage source operands
//   ex_is_load, ex_reg_we, ex_reg_addr - execute-stage destination info
//   pc_chg                      - taken branch resolved in stage 3
//   halt_req                    - level request to freeze the pipeline
//   stall_p1, stall_p2          - hold PC/IF and ID registers
//   bubble_p3                   - inject NOP into stage 3
//   flush_p12                   - squash IF and ID
//   halted                      - frozen by halt
//   stall_cnt, flush_cnt        - saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int LOAD_STALL     = DEF_LOAD_STALL,
  parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [REG_ADDR_WIDTH-1:0] A_addr,
  input  logic [REG_ADDR_WIDTH-1:0] B_addr,
  input  logic                      a_used,
  input  logic                      b_used,
  input  logic                      ex_is_load,
  input  logic                      ex_reg_we,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_addr,
  input  logic                      pc_chg,
  input  logic                      halt_req,
  output logic                      stall_p1,
  output logic                      stall_p2,
  output logic                      bubble_p3,
  output logic                      flush_p12,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int SEQ_W = $clog2(max_int(LOAD_STALL, FLUSH_CYCLES) + 1);
  localparam logic [SEQ_W-1:0] STALL_LOAD = SEQ_W'(LOAD_STALL - 1);
  localparam logic [SEQ_W-1:0] FLUSH_LOAD = SEQ_W'(FLUSH_CYCLES - 1);
  localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);

  hz_state_t        r_state;
  logic [SEQ_W-1:0] r_remain;

  logic w_hazard;
  logic w_stall;
  logic w_flush;
  logic w_halted;
  logic w_flush_evt;

  // Register 0 is an ordinary register here, so no zero-address exemption.
  assign w_hazard = ex_is_load & ex_reg_we &
                    ((a_used & (A_addr == ex_reg_addr)) |
                     (b_used & (B_addr == ex_reg_addr)));

  // RUN is Mealy; STALL only reacts to pc_chg; FLUSH/HALT are pure state decodes.
  always_comb begin
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      HZ_RUN: begin
        if (pc_chg)        w_flush = 1'b1;
        else if (w_hazard) w_stall = 1'b1;
      end
      HZ_STALL: begin
        if (pc_chg) w_flush = 1'b1;
        else        w_stall = 1'b1;
      end
      HZ_FLUSH: w_flush = 1'b1;
      HZ_HALT: begin
        w_stall  = 1'b1;
        w_halted = 1'b1;
      end
      default: ;
    endcase
  end

  // Continuing FLUSH cycles belong to an event already counted.
  assign w_flush_evt = w_flush & (r_state != HZ_FLUSH);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state  <= HZ_RUN;
      r_remain <= '0;
    end else begin
      case (r_state)
        HZ_RUN: begin
          if (pc_chg) begin
            if (FLUSH_CYCLES > 1) begin
              r_state  <= HZ_FLUSH;
              r_remain <= FLUSH_LOAD;
            end
          end else if (w_hazard) begin
            if (LOAD_STALL > 1) begin
              r_state  <= HZ_STALL;
              r_remain <= STALL_LOAD;
            end
          end else if (halt_req) begin
            r_state <= HZ_HALT;
          end
        end
        HZ_STALL: begin
          // A taken branch abandons the stall and restarts as a flush.
          if (pc_chg) begin
            if (FLUSH_CYCLES > 1) begin
              r_state  <= HZ_FLUSH;
              r_remain <= FLUSH_LOAD;
            end else begin
              r_state  <= HZ_RUN;
              r_remain <= '0;
            end
          end else begin
            r_remain <= r_remain - SEQ_ONE;
            if (r_remain == SEQ_ONE) r_state <= HZ_RUN;
          end
        end
        HZ_FLUSH: begin
          r_remain <= r_remain - SEQ_ONE;
          if (r_remain == SEQ_ONE) r_state <= HZ_RUN;
        end
        HZ_HALT: begin
          if (!halt_req) r_state <= HZ_RUN;
        end
        default: r_state <= HZ_RUN;
      endcase
    end
  end

  // RUN decodes are combinational from inputs, so force them low during reset.
  assign stall_p1  = w_stall & ~RST;
  assign stall_p2  = w_stall & ~RST;
  assign bubble_p3 = w_stall & ~RST;
  assign flush_p12 = w_flush & ~RST;
  assign halted    = w_halted & ~RST;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .RST   (RST),
    .inc   (stall_p2),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .RST   (RST),
    .inc   (w_flush_evt & ~RST),
    .count (flush_cnt)
  );

endmodule
